// File: rtl/exu_div_wb_ctl_pkg.sv
// Shared types for the divide writeback controller: tag FSM states,
// queued result entry layout and the wait-counter width.
package swerv_types;

  localparam int DIV_WB_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    KILL = 2'd2
  } div_wb_state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } div_wb_entry_t;

endpackage

// File: rtl/exu_div_wb_ctl_if.sv
// Handshake bundle between decode/divider (master) and the divide
// writeback controller (slave).
interface exu_div_wb_ctl_if;

  logic        div_issue;
  logic [4:0]  div_rd;
  logic        flush_lower;
  logic        div_finish;
  logic [31:0] div_out;
  logic        wb_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_force;
  logic        div_busy;

  modport master (
    output div_issue, div_rd, flush_lower, div_finish, div_out, wb_ready,
    input  wb_valid, wb_rd, wb_data, wb_force, div_busy
  );

  modport slave (
    input  div_issue, div_rd, flush_lower, div_finish, div_out, wb_ready,
    output wb_valid, wb_rd, wb_data, wb_force, div_busy
  );

endinterface

// File: rtl/exu_div_wb_fifo.sv
// Circular result buffer of DEPTH entries. Pointers carry one extra MSB so
// full and empty are distinguishable without a separate count register.
module exu_div_wb_fifo
  import swerv_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   push_i,
  input  div_wb_entry_t          push_data_i,
  input  logic                   pop_i,
  output div_wb_entry_t          head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  div_wb_entry_t mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer advance on accepted push/pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  // Pointer registers, synchronously reset to empty.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an entry is only observed once the pointers say it was written.
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/exu_div_wb_ctl.sv
// Divide writeback controller: tracks the in-flight divide tag, queues
// finished results and presents them to the register-file write port,
// raising wb_force when an entry waits MAX_WAIT cycles or more.
// Optional macro RV_DIV_WB_PERF_EN adds stall and kill performance counters.
module exu_div_wb_ctl
  import swerv_types::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_l,
  exu_div_wb_ctl_if.slave   dif
`ifdef RV_DIV_WB_PERF_EN
  ,
  output logic [15:0]       perf_div_wb_stall,
  output logic [7:0]        perf_div_killed
`endif
);

  localparam int                      AW         = $clog2(DEPTH);
  localparam logic [AW:0]             BUSY_LVL   = (AW+1)'(DEPTH - 1);
  localparam logic [DIV_WB_CNT_W-1:0] MAX_WAIT_C = DIV_WB_CNT_W'(MAX_WAIT);

  div_wb_state_t             state_q, state_d;
  logic [4:0]                tag_q, tag_d;
  logic [DIV_WB_CNT_W-1:0]   wait_q, wait_d;

  div_wb_entry_t             push_entry;
  div_wb_entry_t             head;
  logic                      push;
  logic                      pop;
  logic                      kill_done;
  logic                      load_tag;
  logic                      issue_ok;
  logic                      div_busy;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [AW:0]               fifo_count;

  // Busy while a divide is tracked or when only the reserved slot remains.
  assign div_busy = (state_q != IDLE) || (fifo_count >= BUSY_LVL);
  assign issue_ok = dif.div_issue & ~div_busy;

  // Tag FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_l) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Tag FSM next state. A finish in PEND wins over a same-cycle flush
  // because that result is older than the flushed instructions.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (issue_ok) state_d = PEND;
      PEND: begin
        if (dif.div_finish)       state_d = IDLE;
        else if (dif.flush_lower) state_d = KILL;
      end
      KILL: if (dif.div_finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tag FSM outputs: push on a live finish, discard on a killed one.
  always_comb begin
    push      = 1'b0;
    kill_done = 1'b0;
    load_tag  = 1'b0;
    unique case (state_q)
      IDLE:    load_tag  = issue_ok;
      PEND:    push      = dif.div_finish;
      KILL:    kill_done = dif.div_finish;
      default: ;
    endcase
  end

  // Destination tag of the divide in flight.
  always_comb begin
    tag_d = load_tag ? dif.div_rd : tag_q;
  end

  // Tag register.
  always_ff @(posedge clk) begin
    if (!rst_l) tag_q <= '0;
    else        tag_q <= tag_d;
  end

  assign push_entry.rd   = tag_q;
  assign push_entry.data = dif.div_out;

  exu_div_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_l       (rst_l),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign pop          = ~fifo_empty & dif.wb_ready;
  assign dif.wb_valid = ~fifo_empty;
  assign dif.wb_rd    = fifo_empty ? 5'd0  : head.rd;
  assign dif.wb_data  = fifo_empty ? 32'd0 : head.data;
  assign dif.wb_force = ~fifo_empty && (wait_q >= MAX_WAIT_C);
  assign dif.div_busy = div_busy;

  // Wait counter: age of the head entry while the port is withheld.
  always_comb begin
    wait_d = wait_q;
    if (pop || fifo_empty)  wait_d = '0;
    else if (wait_q != '1)  wait_d = wait_q + 1'b1;
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (!rst_l) wait_q <= '0;
    else        wait_q <= wait_d;
  end

`ifdef RV_DIV_WB_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [7:0]  kill_cnt_q;

  // Saturating stall and kill event counters.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      if (~fifo_empty && ~dif.wb_ready && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (kill_done && (kill_cnt_q != '1))                     kill_cnt_q  <= kill_cnt_q + 1'b1;
    end
  end

  assign perf_div_wb_stall = stall_cnt_q;
  assign perf_div_killed   = kill_cnt_q;
`endif

  // Issuing while busy is an illegal input; the RTL ignores it.
  issue_while_busy_a: assert property (@(posedge clk) disable iff (!rst_l)
    !(dif.div_issue && div_busy));

  // The busy rule reserves a slot, so a push never meets a full buffer.
  push_into_full_a: assert property (@(posedge clk) disable iff (!rst_l)
    !(push && fifo_full));

  // Killed divides are only counted by the optional perf logic.
  logic unused_kill;
  assign unused_kill = kill_done;

endmodule

// File: tb/tb_exu_div_wb_ctl.sv
// Directed bench for exu_div_wb_ctl (DEPTH=2, MAX_WAIT=8, divide latency 34).
module tb_exu_div_wb_ctl;
  import swerv_types::*;

  localparam int DIV_LAT = 34;

  logic clk;
  logic rst_l;
  int   n_checks = 0;
  int   n_pass   = 0;

  exu_div_wb_ctl_if dif ();

`ifdef RV_DIV_WB_PERF_EN
  logic [15:0] perf_stall;
  logic [7:0]  perf_killed;
`endif

  exu_div_wb_ctl #(
    .DEPTH    (2),
    .MAX_WAIT (8)
  ) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .dif   (dif)
`ifdef RV_DIV_WB_PERF_EN
    ,
    .perf_div_wb_stall (perf_stall),
    .perf_div_killed   (perf_killed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          flush_off;   // cycle after issue carrying flush_lower, -1 = none
    logic        exp_valid;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide and drive the divider through its finish cycle.
  // Returns in the cycle after the finish pulse with inputs idle.
  task automatic do_div(input string tag, input logic [4:0] rd, input logic [31:0] data,
                        input int flush_off);
    dif.div_issue = 1'b1;
    dif.div_rd    = rd;
    check({tag, "_busy_at_issue"}, {31'd0, dif.div_busy}, 32'd0);
    next_cycle();
    dif.div_issue = 1'b0;
    dif.div_rd    = 5'd0;
    for (int i = 1; i <= DIV_LAT; i++) begin
      dif.flush_lower = (i == flush_off);
      dif.div_finish  = (i == DIV_LAT);
      dif.div_out     = (i == DIV_LAT) ? data : 32'd0;
      if (i == 1)       check({tag, "_busy_issue_p1"}, {31'd0, dif.div_busy}, 32'd1);
      if (i == DIV_LAT) check({tag, "_busy_finish"},   {31'd0, dif.div_busy}, 32'd1);
      next_cycle();
    end
    dif.flush_lower = 1'b0;
    dif.div_finish  = 1'b0;
    dif.div_out     = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{5'd5,  32'h0000_0007, -1,          1'b1, 5'd5,  32'h0000_0007};
    vecs[1] = '{5'd3,  32'hDEAD_BEEF, 4,           1'b0, 5'd0,  32'h0000_0000};
    vecs[2] = '{5'd9,  32'h0000_0010, DIV_LAT,     1'b1, 5'd9,  32'h0000_0010};
    vecs[3] = '{5'd31, 32'hFFFF_FFFF, -1,          1'b1, 5'd31, 32'hFFFF_FFFF};
    vecs[4] = '{5'd0,  32'h1234_5678, 1,           1'b0, 5'd0,  32'h0000_0000};
    vecs[5] = '{5'd17, 32'h8000_0000, DIV_LAT - 1, 1'b0, 5'd0,  32'h0000_0000};

    rst_l           = 1'b0;
    dif.div_issue   = 1'b0;
    dif.div_rd      = 5'd0;
    dif.flush_lower = 1'b0;
    dif.div_finish  = 1'b0;
    dif.div_out     = 32'd0;
    dif.wb_ready    = 1'b0;
    next_cycle();
    next_cycle();
    rst_l = 1'b1;

    // Reset state.
    check("rst_valid", {31'd0, dif.wb_valid}, 32'd0);
    check("rst_rd",    {27'd0, dif.wb_rd},    32'd0);
    check("rst_data",  dif.wb_data,           32'd0);
    check("rst_force", {31'd0, dif.wb_force}, 32'd0);
    check("rst_busy",  {31'd0, dif.div_busy}, 32'd0);

    // Single divides: plain, killed, flush-with-finish, edge tags/data.
    for (int v = 0; v < 6; v++) begin
      dif.wb_ready = 1'b1;
      do_div($sformatf("v%0d", v), vecs[v].rd, vecs[v].data, vecs[v].flush_off);
      check($sformatf("v%0d_valid", v), {31'd0, dif.wb_valid}, {31'd0, vecs[v].exp_valid});
      check($sformatf("v%0d_rd", v),    {27'd0, dif.wb_rd},    {27'd0, vecs[v].exp_rd});
      check($sformatf("v%0d_data", v),  dif.wb_data,           vecs[v].exp_data);
      check($sformatf("v%0d_busy", v),  {31'd0, dif.div_busy}, {31'd0, vecs[v].exp_valid});
      check($sformatf("v%0d_force", v), {31'd0, dif.wb_force}, 32'd0);
      next_cycle();
      check($sformatf("v%0d_popped", v), {31'd0, dif.wb_valid}, 32'd0);
      check($sformatf("v%0d_idle", v),   {31'd0, dif.div_busy}, 32'd0);
    end

    // Back-pressure: force exactly MAX_WAIT cycles after wb_valid rises.
    dif.wb_ready = 1'b0;
    do_div("bp", 5'd12, 32'h0000_00A5, -1);
    for (int k = 0; k <= 9; k++) begin
      check($sformatf("bp_valid_%0d", k), {31'd0, dif.wb_valid}, 32'd1);
      check($sformatf("bp_force_%0d", k), {31'd0, dif.wb_force}, {31'd0, k >= 8});
      if (k == 9) dif.wb_ready = 1'b1;
      next_cycle();
    end
    check("bp_force_after_pop", {31'd0, dif.wb_force}, 32'd0);
    check("bp_valid_after_pop", {31'd0, dif.wb_valid}, 32'd0);

    // Ordered release under back-pressure; ten pushes wrap the pointers.
    for (int it = 0; it < 5; it++) begin
      for (int r = 1; r <= 2; r++) begin
        logic [31:0] d;
        d = 32'h100 + 32'(it * 2 + r);
        dif.wb_ready = 1'b0;
        do_div($sformatf("wr%0d_%0d", it, r), 5'(r), d, -1);
        check($sformatf("wr%0d_%0d_valid", it, r), {31'd0, dif.wb_valid}, 32'd1);
        check($sformatf("wr%0d_%0d_rd", it, r),    {27'd0, dif.wb_rd},    32'(r));
        check($sformatf("wr%0d_%0d_data", it, r),  dif.wb_data,           d);
        check($sformatf("wr%0d_%0d_busy", it, r),  {31'd0, dif.div_busy}, 32'd1);
        next_cycle();
        check($sformatf("wr%0d_%0d_hold", it, r),  {31'd0, dif.div_busy}, 32'd1);
        dif.wb_ready = 1'b1;
        next_cycle();
        check($sformatf("wr%0d_%0d_empty", it, r), {31'd0, dif.wb_valid}, 32'd0);
        check($sformatf("wr%0d_%0d_free", it, r),  {31'd0, dif.div_busy}, 32'd0);
      end
    end

    // Reset while a divide is pending.
    dif.wb_ready  = 1'b0;
    dif.div_issue = 1'b1;
    dif.div_rd    = 5'd6;
    next_cycle();
    dif.div_issue = 1'b0;
    dif.div_rd    = 5'd0;
    repeat (10) next_cycle();
    check("rp_busy_before", {31'd0, dif.div_busy}, 32'd1);
    rst_l = 1'b0;
    next_cycle();
    rst_l = 1'b1;
    check("rp_valid", {31'd0, dif.wb_valid}, 32'd0);
    check("rp_busy",  {31'd0, dif.div_busy}, 32'd0);
    check("rp_force", {31'd0, dif.wb_force}, 32'd0);
    dif.wb_ready = 1'b1;
    do_div("rp_after", 5'd8, 32'h0000_0088, -1);
    check("rp_after_rd",   {27'd0, dif.wb_rd}, 32'd8);
    check("rp_after_data", dif.wb_data,        32'h88);
    next_cycle();

    // Reset with a queued entry that is already forcing.
    dif.wb_ready = 1'b0;
    do_div("rq", 5'd4, 32'h0000_0044, -1);
    repeat (10) next_cycle();
    check("rq_force_before", {31'd0, dif.wb_force}, 32'd1);
    rst_l = 1'b0;
    next_cycle();
    rst_l = 1'b1;
    check("rq_valid", {31'd0, dif.wb_valid}, 32'd0);
    check("rq_busy",  {31'd0, dif.div_busy}, 32'd0);
    check("rq_force", {31'd0, dif.wb_force}, 32'd0);
    check("rq_rd",    {27'd0, dif.wb_rd},    32'd0);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
